// File: rtl/if_inst_buf_pkg.sv
// Shared constants and helpers for the instruction fetch buffer: reset/enable
// levels, default bus widths, and the occupancy-counter update encoding.
package if_inst_buf_pkg;

    localparam logic RST_ENA         = 1'b1;
    localparam logic CHIP_ENA        = 1'b1;
    localparam int   INST_ADDR_W     = 32;
    localparam int   INST_BUS_W      = 32;
    localparam int   FETCH_BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // Width of an occupancy counter that must also represent the full level.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A simultaneous push and pop leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return CNT_INC;
            2'b01:   return CNT_DEC;
            default: return CNT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/if_inst_buf_sync_fifo.sv
// In-order synchronous FIFO with flush; the head entry is read combinationally
// from the storage array so the consumer sees it in the same cycle.
module if_inst_buf_sync_fifo
    import if_inst_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;
    cnt_op_e          op;

    // A pop on an empty FIFO is ignored rather than corrupting the pointers.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);
    assign op      = cnt_op(do_push, do_pop);

    always_ff @(posedge clk) begin
        if (rst == RST_ENA || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case (op)
                CNT_INC: count <= count + CNT_W'(1);
                CNT_DEC: count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst != RST_ENA && do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_inst_buf.sv
// Instruction fetch buffer between PC and ID: tracks the one-cycle memory read
// in flight, queues returned (pc, inst) pairs, and back-pressures the PC stage.
module if_inst_buf
    import if_inst_buf_pkg::*;
#(
    parameter int DEPTH  = FETCH_BUF_DEPTH,
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst_i,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              stall_req
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int ENT_W = ADDR_W + INST_W;

    logic              req_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic              issue;
    logic              push;
    logic              pop;

    // The in-flight request already owns a slot, so it counts toward full.
    // A same-cycle pop is deliberately not credited to keep this register-only.
    assign stall_req = ({1'b0, count} + {{CNT_W{1'b0}}, req_q}) >= (CNT_W+1)'(DEPTH);
    assign issue     = (ce == CHIP_ENA) & ~stall_req & ~flush;
    assign push      = req_q & ~flush;
    assign pop       = id_valid & id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            req_q <= 1'b0;
            pc_q  <= '0;
        end else begin
            req_q <= issue;
            pc_q  <= pc;
        end
    end

    if_inst_buf_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({pc_q, inst_i}),
        .count (count),
        .head  (head)
    );

    // Stale storage contents never leak to ID while the buffer is empty.
    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? head[ENT_W-1:INST_W] : '0;
    assign id_inst  = id_valid ? head[INST_W-1:0]     : '0;

endmodule
